// File: rtl/fpdsp_arbiter.sv
// Round-robin front end for a shared iterative FP DSP core: grants one requester at a time,
// launches the core, waits for ready under a watchdog and hands the result back to the owner.
module fpdsp_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    op,
    input  logic [32*NREQ-1:0]   a,
    input  logic [32*NREQ-1:0]   b,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [31:0]          result,
    output logic                 err,
    output logic                 core_run,
    output logic [1:0]           core_op,
    output logic [31:0]          core_a,
    output logic [31:0]          core_b,
    input  logic                 core_ready,
    input  logic [31:0]          core_result
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETIRE} state_t;

    state_t          state, state_d;
    logic [IW-1:0]   owner, owner_d;
    logic [IW-1:0]   ptr, ptr_d;
    logic [IW-1:0]   pick, idx;
    logic            found;
    logic [WW-1:0]   wdog, wdog_d;
    logic [31:0]     res_lat, res_lat_d;
    logic            err_lat, err_lat_d;

    logic [NREQ-1:0] gnt_d, done_d;
    logic [31:0]     result_d, core_a_d, core_b_d;
    logic            err_d, core_run_d;
    logic [1:0]      core_op_d;

    logic [1:0]      op_s [NREQ];
    logic [31:0]     a_s  [NREQ];
    logic [31:0]     b_s  [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign op_s[i] = op[2*i +: 2];
        assign a_s[i]  = a[32*i +: 32];
        assign b_s[i]  = b[32*i +: 32];
    end

    // Search starts one past the last owner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d    = state;
        owner_d    = owner;
        ptr_d      = ptr;
        wdog_d     = wdog;
        res_lat_d  = res_lat;
        err_lat_d  = err_lat;
        core_op_d  = core_op;
        core_a_d   = core_a;
        core_b_d   = core_b;
        gnt_d      = '0;
        done_d     = '0;
        result_d   = '0;
        err_d      = 1'b0;
        core_run_d = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    owner_d   = pick;
                    core_op_d = op_s[pick];
                    core_a_d  = a_s[pick];
                    core_b_d  = b_s[pick];
                    gnt_d     = NREQ'(1) << pick;
                    if (op_s[pick] == OP_RSV) begin
                        res_lat_d = '0;
                        err_lat_d = 1'b1;
                        state_d   = RETIRE;
                    end else begin
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                core_run_d = 1'b1;
                wdog_d     = '0;
                state_d    = WAIT;
            end
            // A ready arriving on the same cycle as the watchdog expiry still counts.
            WAIT: begin
                wdog_d = wdog + WW'(1);
                if (core_ready) begin
                    res_lat_d = core_result;
                    err_lat_d = 1'b0;
                    state_d   = RETIRE;
                end else if (wdog_d == WW'(TIMEOUT - 1)) begin
                    res_lat_d = '0;
                    err_lat_d = 1'b1;
                    state_d   = RETIRE;
                end
            end
            RETIRE: begin
                done_d   = NREQ'(1) << owner;
                result_d = res_lat;
                err_d    = err_lat;
                ptr_d    = owner;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= IW'(NREQ - 1);
            wdog     <= '0;
            res_lat  <= '0;
            err_lat  <= 1'b0;
            gnt      <= '0;
            done     <= '0;
            result   <= '0;
            err      <= 1'b0;
            core_run <= 1'b0;
            core_op  <= '0;
            core_a   <= '0;
            core_b   <= '0;
        end else begin
            state    <= state_d;
            owner    <= owner_d;
            ptr      <= ptr_d;
            wdog     <= wdog_d;
            res_lat  <= res_lat_d;
            err_lat  <= err_lat_d;
            gnt      <= gnt_d;
            done     <= done_d;
            result   <= result_d;
            err      <= err_d;
            core_run <= core_run_d;
            core_op  <= core_op_d;
            core_a   <= core_a_d;
            core_b   <= core_b_d;
        end
    end

endmodule

// File: tb/tb_fpdsp_arbiter.sv
// Self-checking bench for fpdsp_arbiter: a transaction-level model predicts grants, core starts
// and completions cycle by cycle while directed and random requesters plus a core model drive it.
module tb_fpdsp_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [2*NREQ-1:0]   op;
    logic [32*NREQ-1:0]  a, b;
    logic [NREQ-1:0]     gnt, done;
    logic [31:0]         result;
    logic                err;
    logic                core_run;
    logic [1:0]          core_op;
    logic [31:0]         core_a, core_b;
    logic                core_ready;
    logic [31:0]         core_result;

    always #5 clk = ~clk;

    fpdsp_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b),
        .gnt(gnt), .done(done), .result(result), .err(err),
        .core_run(core_run), .core_op(core_op), .core_a(core_a), .core_b(core_b),
        .core_ready(core_ready), .core_result(core_result)
    );

    // Requester-side state, mapped onto the packed DUT buses.
    bit          r_req [NREQ];
    logic [1:0]  r_op  [NREQ];
    logic [31:0] r_a   [NREQ];
    logic [31:0] r_b   [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_drive
        assign req[g]        = r_req[g];
        assign op[2*g +: 2]  = r_op[g];
        assign a[32*g +: 32] = r_a[g];
        assign b[32*g +: 32] = r_b[g];
    end

    int errs = 0, checks = 0, cyc = 0;

    bit auto_req = 0, keep_on_gnt = 0, noise = 0, allow_rsv = 0, lat_rand = 0, fix_ret_en = 0;
    int p_raise = 0, p_drop = 0, force_op = -1, lat_fix = 3;
    logic [31:0] fix_ret = '0;

    // Reference model: one transaction in flight, absolute cycle numbers for each event.
    bit          mbusy;
    int          mptr, mown, run_at, done_at, ready_at, granted_now;
    logic [1:0]  mop;
    logic [31:0] ma, mb, mres, ret_val;
    bit          merr;

    logic [NREQ-1:0] gq [$];
    logic [NREQ-1:0] obs_done;
    logic [31:0]     obs_res;
    logic            obs_err;
    int gnt_cyc, run_cyc, done_cyc, runs, dones;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pickNext(int p);
        for (int k = 1; k <= NREQ; k++)
            if (r_req[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic bit anyReq();
        for (int i = 0; i < NREQ; i++) if (r_req[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic modelReset();
        mbusy = 0; mptr = NREQ - 1; mown = 0;
        run_at = -1; done_at = -1; ready_at = -1; granted_now = -1;
    endtask

    task automatic newOperands(input int i);
        if (force_op >= 0)  r_op[i] = 2'(force_op);
        else if (allow_rsv) r_op[i] = 2'($urandom % 4);
        else                r_op[i] = 2'($urandom % 3);
        r_a[i] = $urandom;
        r_b[i] = $urandom;
    endtask

    task automatic checkOutput();
        logic [NREQ-1:0] eg, ed;
        logic            er, ee;
        logic [31:0]     eres;
        int              pk, lat;
        granted_now = -1;
        if (gnt != 0)      begin gq.push_back(gnt); gnt_cyc = cyc; end
        if (core_run)      begin runs++; run_cyc = cyc; end
        if (done != 0)     begin dones++; obs_done = done; obs_res = result; obs_err = err; done_cyc = cyc; end
        if (rst) begin
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_result", result, 0);
            chk("rst_err", 32'(err), 0);
            chk("rst_core_run", 32'(core_run), 0);
            chk("rst_core_op", 32'(core_op), 0);
            chk("rst_core_a", core_a, 0);
            chk("rst_core_b", core_b, 0);
            modelReset();
            return;
        end
        eg = '0; ed = '0; er = 1'b0; ee = 1'b0; eres = '0; pk = -1;
        if (!mbusy) begin
            pk = pickNext(mptr);
            if (pk >= 0) eg = NREQ'(1) << pk;
        end
        if (mbusy && run_at == cyc) er = 1'b1;
        if (mbusy && done_at == cyc) begin
            ed = NREQ'(1) << mown; eres = mres; ee = merr;
        end
        chk("gnt", 32'(gnt), 32'(eg));
        chk("core_run", 32'(core_run), 32'(er));
        chk("done", 32'(done), 32'(ed));
        chk("result", result, eres);
        chk("err", 32'(err), 32'(ee));
        if (er) begin
            chk("core_op", 32'(core_op), 32'(mop));
            chk("core_a", core_a, ma);
            chk("core_b", core_b, mb);
        end
        if (pk >= 0) begin
            mbusy = 1; mown = pk; granted_now = pk;
            mop = r_op[pk]; ma = r_a[pk]; mb = r_b[pk];
            ready_at = -1;
            if (mop == 2'b11) begin
                run_at = -1; done_at = cyc + 1; mres = '0; merr = 1;
            end else begin
                run_at = cyc + 1; done_at = -1;
            end
        end
        // A core answer counts only if it is sampled no later than the watchdog expiry.
        if (er) begin
            if (lat_rand) lat = ($urandom % 16 == 0) ? TIMEOUT + int'($urandom % 4) : int'($urandom % 8);
            else          lat = lat_fix;
            ret_val = fix_ret_en ? fix_ret : $urandom;
            if (lat >= 0 && lat <= TIMEOUT - 2) begin
                ready_at = cyc + lat; done_at = cyc + lat + 2; mres = ret_val; merr = 0;
            end else begin
                ready_at = -1; done_at = cyc + TIMEOUT; mres = '0; merr = 1;
            end
        end
        if (ed != 0) begin
            mbusy = 0; mptr = mown;
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NREQ; i++) begin
            if (granted_now == i) begin
                if (keep_on_gnt || (auto_req && $urandom % 2 == 1)) newOperands(i);
                else r_req[i] = 1'b0;
            end else if (auto_req) begin
                if (!r_req[i] && $urandom % 100 < p_raise) begin
                    r_req[i] = 1'b1; newOperands(i);
                end else if (r_req[i] && $urandom % 100 < p_drop) begin
                    r_req[i] = 1'b0;
                end
            end
        end
        core_ready  = 1'b0;
        core_result = $urandom;
        if (mbusy && run_at >= 0 && cyc >= run_at) begin
            if (cyc == ready_at) begin
                core_ready  = 1'b1;
                core_result = ret_val;
            end
        end else if (noise) begin
            core_ready = 1'($urandom % 2);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        checkOutput();
        applyStimulus();
    endtask

    task automatic waitIdle(input int budget);
        int k;
        k = 0;
        cycle();
        while ((mbusy || anyReq()) && k < budget) begin
            cycle();
            k++;
        end
        chk("idle_reached", 32'(mbusy || anyReq()), 0);
    endtask

    initial begin
        rst = 1'b1; core_ready = 1'b0; core_result = '0;
        for (int i = 0; i < NREQ; i++) begin r_req[i] = 0; r_op[i] = '0; r_a[i] = '0; r_b[i] = '0; end
        modelReset();
        runs = 0; dones = 0; gnt_cyc = 0; run_cyc = 0; done_cyc = 0;
        obs_done = '0; obs_res = '0; obs_err = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
        cycle();

        $display("[TB] continuous mul requests from all requesters");
        force_op = 2; keep_on_gnt = 1; lat_fix = 3; gq.delete();
        for (int i = 0; i < NREQ; i++) begin r_req[i] = 1; newOperands(i); end
        for (int k = 0; k < 300 && gq.size() < 5; k++) cycle();
        for (int k = 0; k < 5; k++)
            chk($sformatf("order%0d", k), (gq.size() > k) ? 32'(gq[k]) : 32'hFFFF_FFFF, 32'(NREQ'(1) << (k % NREQ)));
        keep_on_gnt = 0; force_op = -1;
        waitIdle(400);

        $display("[TB] single request on requester 2");
        fix_ret_en = 1; fix_ret = 32'h4040_0000; lat_fix = 5; gq.delete();
        r_req[2] = 1; r_op[2] = 2'b00; r_a[2] = 32'h3F80_0000; r_b[2] = 32'h4000_0000;
        waitIdle(100);
        fix_ret_en = 0;
        chk("single_gnt", (gq.size() > 0) ? 32'(gq[0]) : 0, 32'h4);
        chk("single_run_lat", 32'(run_cyc - gnt_cyc), 1);
        chk("single_done", 32'(obs_done), 32'h4);
        chk("single_result", obs_res, 32'h4040_0000);
        chk("single_err", 32'(obs_err), 0);

        $display("[TB] reserved op on requester 1");
        runs = 0; gq.delete();
        r_req[1] = 1; r_op[1] = 2'b11; r_a[1] = $urandom; r_b[1] = $urandom;
        waitIdle(50);
        chk("rsv_gnt", (gq.size() > 0) ? 32'(gq[0]) : 0, 32'h2);
        chk("rsv_done", 32'(obs_done), 32'h2);
        chk("rsv_err", 32'(obs_err), 1);
        chk("rsv_result", obs_res, 0);
        chk("rsv_latency", 32'(done_cyc - gnt_cyc), 1);
        chk("rsv_no_run", 32'(runs), 0);

        $display("[TB] watchdog abort, then a normal request");
        lat_fix = -1;
        r_req[0] = 1; r_op[0] = 2'b00; r_a[0] = $urandom; r_b[0] = $urandom;
        waitIdle(200);
        chk("wd_err", 32'(obs_err), 1);
        chk("wd_result", obs_res, 0);
        chk("wd_latency", 32'(done_cyc - run_cyc), TIMEOUT);
        lat_fix = 4;
        r_req[3] = 1; r_op[3] = 2'b01; r_a[3] = $urandom; r_b[3] = $urandom;
        waitIdle(100);
        chk("post_wd_done", 32'(obs_done), 32'h8);
        chk("post_wd_err", 32'(obs_err), 0);

        $display("[TB] stray core_ready in IDLE and ready coinciding with timeout");
        noise = 1; dones = 0;
        repeat (12) cycle();
        chk("idle_ready_nodone", 32'(dones), 0);
        lat_fix = TIMEOUT - 2; fix_ret_en = 1; fix_ret = 32'h1234_5678;
        r_req[2] = 1; r_op[2] = 2'b10; r_a[2] = $urandom; r_b[2] = $urandom;
        waitIdle(200);
        chk("coinc_err", 32'(obs_err), 0);
        chk("coinc_result", obs_res, 32'h1234_5678);
        chk("coinc_latency", 32'(done_cyc - run_cyc), TIMEOUT);
        fix_ret_en = 0; noise = 0;

        $display("[TB] random traffic");
        auto_req = 1; p_raise = 25; p_drop = 4; allow_rsv = 1; lat_rand = 1; noise = 1;
        repeat (800) cycle();
        auto_req = 0; noise = 0; allow_rsv = 0; lat_rand = 0;
        for (int i = 0; i < NREQ; i++) r_req[i] = 0;
        waitIdle(200);

        $display("[TB] reset while waiting on the core");
        lat_fix = 40;
        r_req[1] = 1; r_op[1] = 2'b00; r_a[1] = $urandom; r_b[1] = $urandom;
        for (int k = 0; k < 50 && !(mbusy && run_at >= 0 && cyc >= run_at + 3); k++) cycle();
        chk("reached_wait", 32'(mbusy && run_at >= 0 && cyc >= run_at + 3), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_gnt", 32'(gnt), 0);
        chk("async_done", 32'(done), 0);
        chk("async_result", result, 0);
        chk("async_err", 32'(err), 0);
        chk("async_core_run", 32'(core_run), 0);
        chk("async_core_op", 32'(core_op), 0);
        chk("async_core_a", core_a, 0);
        chk("async_core_b", core_b, 0);
        for (int i = 0; i < NREQ; i++) r_req[i] = 0;
        dones = 0;
        cycle(); cycle();
        rst = 1'b0;
        lat_fix = 2; gq.delete();
        for (int i = 0; i < NREQ; i++) begin r_req[i] = 1; r_op[i] = 2'b00; r_a[i] = $urandom; r_b[i] = $urandom; end
        waitIdle(300);
        chk("post_rst_first", (gq.size() > 0) ? 32'(gq[0]) : 0, 32'h1);
        chk("post_rst_dones", 32'(dones), NREQ);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
